delay_15_measure: RTL

Measures the delay of a 1-bit stream against its source. It is the receive-side counterpart of `delay_15`. The block watches a reference stream `ref_i` and a returned stream `echo_i`, then finds the single delay d in 1..15 for which `echo_i` has matched `ref_i` delayed by d for WINDOW consecutive cycles. It is used to calibrate or check programmable delay lines: it produces the delay value that `delay_15` was configured with.

---
 rtl/delay_15_pkg.sv | 7 +
 rtl/delay_15_tap_cnt.sv | 32 +++
 rtl/delay_15_measure.sv | 122 ++++++++++++
 3 files changed

// File: rtl/delay_15_pkg.sv
// Shared constants and FSM state type for the delay_15 measurement block.
package delay_15_pkg;
  localparam int MAX_DELAY = 15;
  localparam int DELAY_W   = 4;

  typedef enum logic [1:0] {IDLE, FILL, SEARCH, DONE} meas_state_t;
endpackage

// File: rtl/delay_15_tap_cnt.sv
// One candidate delay: counts consecutive cycles where echo equals the
// delayed reference bit, saturating at WINDOW; hit flags a full window.
module delay_15_tap_cnt #(
  parameter int WINDOW = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hist_bit,
  input  logic echo,
  input  logic en,
  input  logic clr,
  output logic hit
);
  localparam int CW = $clog2(WINDOW + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en) begin
      if (hist_bit != echo)
        cnt <= '0;
      else if (cnt != CW'(WINDOW))
        cnt <= cnt + CW'(1);
    end
  end

  assign hit = (cnt == CW'(WINDOW));
endmodule

// File: rtl/delay_15_measure.sv
// Finds the single delay 1..15 at which echo_i tracks ref_i for WINDOW cycles.
// Optional ambig_o output is enabled by defining DELAY_15_MEASURE_AMBIG_EN.
module delay_15_measure
  import delay_15_pkg::*;
#(
  parameter int WINDOW  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               ref_i,
  input  logic               echo_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               found_o,
  output logic [DELAY_W-1:0] delay_o
`ifdef DELAY_15_MEASURE_AMBIG_EN
  , output logic             ambig_o
`endif
);
  localparam int TW = $clog2(TIMEOUT + 1);

  meas_state_t              state, nx_state;
  logic [MAX_DELAY:1]       hist;
  logic [MAX_DELAY:1]       hit;
  logic [3:0]               fill_cnt;
  logic [TW-1:0]            tcnt;
  logic                     lock, multi, tmo, finish;
  logic [DELAY_W-1:0]       lock_d;
  logic                     busy_nx, done_nx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hist <= '0;
    else         hist <= {hist[MAX_DELAY-1:1], ref_i};
  end

  for (genvar g = 1; g <= MAX_DELAY; g++) begin : g_tap
    delay_15_tap_cnt #(.WINDOW(WINDOW)) u_tap (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .hist_bit (hist[g]),
      .echo     (echo_i),
      .en       (state == SEARCH),
      .clr      (state != SEARCH),
      .hit      (hit[g])
    );
  end

  // Lock needs exactly one full window; several at once means ambiguity.
  assign multi = (hit & (hit - MAX_DELAY'(1))) != '0;
  assign lock  = (hit != '0) && !multi;
  assign tmo   = (tcnt == TW'(TIMEOUT));
  assign finish = lock || tmo;

  always_comb begin
    lock_d = '0;
    for (int k = 1; k <= MAX_DELAY; k++)
      if (hit[k]) lock_d = DELAY_W'(k);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= nx_state;
  end

  always_comb begin
    nx_state = state;
    case (state)
      IDLE:    if (start_i)          nx_state = FILL;
      FILL:    if (fill_cnt == 4'd0) nx_state = SEARCH;
      SEARCH:  if (finish)           nx_state = DONE;
      DONE:                          nx_state = IDLE;
      default:                       nx_state = IDLE;
    endcase
  end

  always_comb begin
    busy_nx = (nx_state == FILL) || (nx_state == SEARCH);
    done_nx = (nx_state == DONE);
  end

  // Fill runs 15 cycles so every tap sees post-start reference data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_cnt <= '0;
      tcnt     <= '0;
    end else begin
      if (state == IDLE && start_i)        fill_cnt <= 4'd14;
      else if (state == FILL && fill_cnt != 4'd0) fill_cnt <= fill_cnt - 4'd1;
      if (state == FILL)                   tcnt <= '0;
      else if (state == SEARCH && !tmo)    tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      found_o <= 1'b0;
      delay_o <= '0;
    end else begin
      busy_o <= busy_nx;
      done_o <= done_nx;
      if (state == IDLE && start_i) begin
        found_o <= 1'b0;
        delay_o <= '0;
      end else if (state == SEARCH && finish) begin
        found_o <= lock;
        delay_o <= lock ? lock_d : '0;
      end
    end
  end

`ifdef DELAY_15_MEASURE_AMBIG_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         ambig_o <= 1'b0;
    else if (state == IDLE && start_i)   ambig_o <= 1'b0;
    else if (state == SEARCH && finish)  ambig_o <= !lock && multi;
  end
`endif
endmodule
